descriptor_memory_arbiter: RTL
==============================

Name: descriptor_memory_arbiter

Overview:
- Two-master arbiter and burst sequencer for the 2048x32 single-port descriptor RAM in the Qsys system.
- Shares the one RAM port between m0 (CPU/control master) and m1 (DMA descriptor fetch/writeback).
- Uses round-robin grant and converts Avalon-MM bursts into single-beat RAM accesses.
- RAM read latency is 1 clock: address presented in cycle N gives mem_readdata in cycle N+1.

Parameters:
ADDR_W, 11, word address width; the RAM depth is 2^ADDR_W.
DATA_W, 32, data width.
BE_W, 4, byteenable width (DATA_W/8).
BURST_W, 4, burstcount width; legal bursts are 1..15.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high reset.
mN_address  in  ADDR_W  word address; N=0,1 for each mN_ port.
mN_byteenable  in  BE_W  write byte lanes.
mN_read  in  1  read request.
mN_write  in  1  write request or beat.
mN_writedata  in  DATA_W  write data.
mN_burstcount  in  BURST_W  beats; 0 is treated as 1.
mN_waitrequest  out  1  low means the command or beat is accepted this cycle.
mN_readdata  out  DATA_W  read data.
mN_readdatavalid  out  1  read beat valid.
mem_address  out  ADDR_W  RAM address.
mem_byteenable  out  BE_W  RAM byteenable.
mem_chipselect  out  1  RAM select.
mem_write  out  1  RAM write.
mem_writedata  out  DATA_W  RAM write data.
mem_clken  out  1  RAM clock enable; tied to 1.
mem_readdata  in  DATA_W  RAM read data, 1-cycle latency.

Behaviour:
- States: IDLE, RD, WR.
- Reset forces IDLE, both waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, last_grant=1 (m0 wins first).
- Reset mid-burst abandons the burst and drops read data still in flight.
- IDLE arbitration:
  - A master requests when read|write is high.
  - If one master requests, it wins.
  - If both request, the master that is not last_grant wins.
  - On a win: register winner id, address (base), burstcount (0→1) into beats, and offset=0. Update last_grant. Go to RD, or to WR if write is high.
  - If a master asserts read and write together, write wins and read is ignored.
  - waitrequest is high for both masters in IDLE.
- RD state:
  - Winner's waitrequest is low in the first RD cycle only; that is the command accept.
  - Every RD cycle drives mem_chipselect=1, mem_address=(base+offset) mod 2^ADDR_W, then offset++.
  - After beats addresses have been issued, return to IDLE.
  - Readdata path: a registered valid pipe carries the winner id. mN_readdatavalid is asserted the cycle after each address issue, and mN_readdata=mem_readdata.
  - The valid pipe runs independently of state, so the last beat completes in the IDLE cycle after RD.
- Read timing: request at T (IDLE) → accept at T+1 → data at T+2..T+1+beats → IDLE at T+1+beats.
- WR state:
  - Winner's waitrequest=0 in each cycle the winner holds write=1.
  - Each such cycle drives mem_chipselect=1, mem_write=1, mem_address=base+offset (wrapping), with byteenable and writedata passed through from the winner, then offset++.
  - If write is low mid-burst: stall; no RAM access and offset held.
  - Return to IDLE after beats accepted beats.
- The loser's waitrequest stays high throughout; no preemption mid-burst.
- Max occupancy per grant is 16 cycles, including arbitration.
- A master with no pending request never blocks the other.
- Non-winning mN_readdatavalid=0; mN_readdata is don't-care when readdatavalid=0.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to 0x010 (burst 1, be=0xF) → mem_write pulses 1 cycle at 0x010; m0 reads 0x010 → readdatavalid at T+2 with 0xDEADBEEF.
- m1 reads burst 4 at 0x7FE → mem_address sequence 0x7FE, 0x7FF, 0x000, 0x001; 4 consecutive readdatavalid pulses on m1 only.
- m0 and m1 request simultaneously, repeated 3 times → grants alternate m0, m1, m0 after reset; loser's waitrequest stays high until its own grant.
- m0 write burst 3 with write deasserted for 2 cycles after beat 1 → exactly 3 mem_write pulses at base, +1, +2; no RAM access while stalled.
- Reset asserted during an m1 read burst 8 after 3 beats → next cycle all readdatavalid=0, state IDLE; following m0 request is granted normally.
- burstcount=0 read at 0x100 → exactly one readdatavalid beat.

Source files
------------

// File: rtl/descriptor_memory_arbiter.sv
// Two-master round-robin arbiter and burst sequencer for the single-port
// descriptor RAM. Avalon-MM bursts from m0 (control) and m1 (DMA) are
// split into single-beat RAM accesses; the RAM answers reads one cycle
// after the address is presented.
//
// Handshake: a command or write beat from mN is accepted in exactly the
// cycles where mN_waitrequest is low. A read burst is accepted once, in
// the first RD cycle. Each write beat is accepted in a WR cycle where the
// winner holds write high. Read beats are returned as mN_readdatavalid
// pulses. There is no back-pressure on read data.
module descriptor_memory_arbiter #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 32,
   parameter int BE_W    = 4,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  m0_address,
   input  logic [BE_W-1:0]    m0_byteenable,
   input  logic               m0_read,
   input  logic               m0_write,
   input  logic [DATA_W-1:0]  m0_writedata,
   input  logic [BURST_W-1:0] m0_burstcount,
   output logic               m0_waitrequest,
   output logic [DATA_W-1:0]  m0_readdata,
   output logic               m0_readdatavalid,
   input  logic [ADDR_W-1:0]  m1_address,
   input  logic [BE_W-1:0]    m1_byteenable,
   input  logic               m1_read,
   input  logic               m1_write,
   input  logic [DATA_W-1:0]  m1_writedata,
   input  logic [BURST_W-1:0] m1_burstcount,
   output logic               m1_waitrequest,
   output logic [DATA_W-1:0]  m1_readdata,
   output logic               m1_readdatavalid,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BE_W-1:0]    mem_byteenable,
   output logic               mem_chipselect,
   output logic               mem_write,
   output logic [DATA_W-1:0]  mem_writedata,
   output logic               mem_clken,
   input  logic [DATA_W-1:0]  mem_readdata,
   output logic [1:0]         dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 last_grant_q, last_grant_d;  // 1 = m1 served last
   logic                 win_q, win_d;                // 0 = m0, 1 = m1
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [BURST_W-1:0]   beats_q, beats_d;
   logic [BURST_W-1:0]   offset_q, offset_d;
   logic                 rvalid_q, rvalid_d;          // read return pipe
   logic                 rid_q, rid_d;

   logic                 req0, req1, pick1, accept;
   logic                 w_write;
   logic [BE_W-1:0]      w_be;
   logic [DATA_W-1:0]    w_wdata;
   logic [BURST_W-1:0]   new_bc;
   logic                 last_beat;

   assign req0      = m0_read | m0_write;
   assign req1      = m1_read | m1_write;
   // On a tie the master that was not served last wins.
   assign pick1     = req1 & (~req0 | ~last_grant_q);
   assign new_bc    = pick1 ? m1_burstcount : m0_burstcount;
   assign w_write   = win_q ? m1_write      : m0_write;
   assign w_be      = win_q ? m1_byteenable : m0_byteenable;
   assign w_wdata   = win_q ? m1_writedata  : m0_writedata;
   assign last_beat = (BURST_W'(offset_q + 1'b1) == beats_q);

   // Arbitration, burst sequencing and RAM command generation.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      win_d          = win_q;
      base_d         = base_q;
      beats_d        = beats_q;
      offset_d       = offset_q;
      rvalid_d       = 1'b0;
      rid_d          = win_q;
      accept         = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = base_q + ADDR_W'(offset_q);
      mem_byteenable = '1;
      mem_writedata  = w_wdata;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               win_d        = pick1;
               last_grant_d = pick1;
               base_d       = pick1 ? m1_address : m0_address;
               beats_d      = (new_bc == '0) ? BURST_W'(1) : new_bc;
               offset_d     = '0;
               // A simultaneous read and write is treated as a write.
               state_d      = (pick1 ? m1_write : m0_write) ? WR : RD;
            end
         end
         RD: begin
            accept         = (offset_q == '0);
            mem_chipselect = 1'b1;
            rvalid_d       = 1'b1;
            offset_d       = offset_q + 1'b1;
            if (last_beat) state_d = IDLE;
         end
         WR: begin
            if (w_write) begin
               accept         = 1'b1;
               mem_chipselect = 1'b1;
               mem_write      = 1'b1;
               mem_byteenable = w_be;
               offset_d       = offset_q + 1'b1;
               if (last_beat) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any burst and in-flight read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         base_q       <= '0;
         beats_q      <= BURST_W'(1);
         offset_q     <= '0;
         rvalid_q     <= 1'b0;
         rid_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         base_q       <= base_d;
         beats_q      <= beats_d;
         offset_q     <= offset_d;
         rvalid_q     <= rvalid_d;
         rid_q        <= rid_d;
      end
   end

   assign m0_waitrequest   = ~(accept & ~win_q);
   assign m1_waitrequest   = ~(accept &  win_q);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rvalid_q & ~rid_q;
   assign m1_readdatavalid = rvalid_q &  rid_q;
   assign mem_clken        = 1'b1;
   assign dbg_state_o      = state_q;

endmodule
